// File: rtl/simon_pkg.sv
// Shared constants, FSM state encoding and the rotate helper for the Simon 128/256 round engine.
package simon_pkg;
  localparam int ROUNDS  = 72;
  localparam int WORD_W  = 64;
  localparam int KEY_LAT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction
endpackage

// File: rtl/simon_round_f.sv
// Simon round function f(a) folded with the key and partner-word XOR; used for both directions.
module simon_round_f
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] f_in,
  input  logic [WORD_W-1:0] xor_in,
  input  logic [WORD_W-1:0] k,
  output logic [WORD_W-1:0] res
);
  assign res = xor_in ^ k ^ ((rotl(f_in, 1) & rotl(f_in, 8)) ^ rotl(f_in, 2));
endmodule

// File: rtl/simon_round_engine.sv
// Iterative Simon 128/256 engine: streams 72 key reads, one Feistel round per returned key.
// Optional decrypt path enabled by defining SIMON_DECRYPT_EN.
module simon_round_engine
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                key_compute_start,
  input  logic                key_mem_full,
  output logic                key_rd_en,
  output logic [8:0]          key_addr,
  input  logic [WORD_W-1:0]   key_data,
  input  logic                key_data_vld,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [2*WORD_W-1:0] in_data,
`ifdef SIMON_DECRYPT_EN
  input  logic                in_decrypt,
`endif
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [2*WORD_W-1:0] out_data,
  output logic                busy
);
  localparam logic [6:0] NRD  = 7'(ROUNDS);
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  state_t            state, state_nxt;
  logic              keys_ok;
  logic [6:0]        rd_cnt, rx_cnt;
  logic [WORD_W-1:0] x, y, f_in, xor_in, f_out;
  logic              accept, abort, round_en;

  assign accept   = (state == IDLE) && in_vld && keys_ok;
  assign abort    = (state == RUN) && key_compute_start;
  assign round_en = (state == RUN) && key_data_vld && !abort;

`ifdef SIMON_DECRYPT_EN
  logic decrypt;

  always_ff @(posedge clk) begin
    if (rst)         decrypt <= 1'b0;
    else if (accept) decrypt <= in_decrypt;
  end

  // Decrypt runs f on y and walks the key memory from the top down.
  assign f_in     = decrypt ? y : x;
  assign xor_in   = decrypt ? x : y;
  assign key_addr = {2'b00, decrypt ? (LAST - rd_cnt) : rd_cnt};
`else
  assign f_in     = x;
  assign xor_in   = y;
  assign key_addr = {2'b00, rd_cnt};
`endif

  simon_round_f u_round_f (
    .f_in   (f_in),
    .xor_in (xor_in),
    .k      (key_data),
    .res    (f_out)
  );

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    key_rd_en = 1'b0;
    out_vld   = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = keys_ok;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        key_rd_en = (rd_cnt < NRD);
        if (abort)                               state_nxt = IDLE;
        else if (key_data_vld && rx_cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign out_data = (state == DONE) ? {x, y} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      keys_ok <= 1'b0;
      rd_cnt  <= '0;
      rx_cnt  <= '0;
      x       <= '0;
      y       <= '0;
    end else begin
      state <= state_nxt;
      // A restart wins over a same-cycle full pulse.
      if (key_compute_start) keys_ok <= 1'b0;
      else if (key_mem_full) keys_ok <= 1'b1;

      if (accept) begin
        x      <= in_data[2*WORD_W-1:WORD_W];
        y      <= in_data[WORD_W-1:0];
        rd_cnt <= '0;
        rx_cnt <= '0;
      end else if (abort) begin
        rd_cnt <= '0;
        rx_cnt <= '0;
      end else begin
        if (key_rd_en) rd_cnt <= rd_cnt + 7'd1;
        if (round_en) begin
          rx_cnt <= rx_cnt + 7'd1;
`ifdef SIMON_DECRYPT_EN
          if (decrypt) begin
            x <= y;
            y <= f_out;
          end else
`endif
          begin
            x <= f_out;
            y <= x;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_simon_round_engine.sv
// Directed bench for simon_round_engine with a key-memory responder and a Simon 128/256 reference model.
module tb_simon_round_engine;
  import simon_pkg::*;

  localparam logic [255:0] KEY = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT  = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] CT  = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_compute_start, key_mem_full;
  logic         key_rd_en;
  logic [8:0]   key_addr;
  logic [63:0]  key_data;
  logic         key_data_vld;
  logic         in_vld, in_rdy;
  logic [127:0] in_data;
`ifdef SIMON_DECRYPT_EN
  logic         in_decrypt;
`endif
  logic         out_vld, out_rdy;
  logic [127:0] out_data;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_rd    = 0;
  logic [8:0]  addr_q [$];
  logic [63:0] rk [72];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simon_round_engine dut (
    .clk               (clk),
    .rst               (rst),
    .key_compute_start (key_compute_start),
    .key_mem_full      (key_mem_full),
    .key_rd_en         (key_rd_en),
    .key_addr          (key_addr),
    .key_data          (key_data),
    .key_data_vld      (key_data_vld),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .in_data           (in_data),
`ifdef SIMON_DECRYPT_EN
    .in_decrypt        (in_decrypt),
`endif
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .out_data          (out_data),
    .busy              (busy)
  );

  // Key memory read port: data returns KEY_LAT cycles after each strobe.
  logic [KEY_LAT-1:0] vld_pipe = '0;
  logic [8:0]         addr_pipe [KEY_LAT];
  always @(posedge clk) begin
    vld_pipe     <= {vld_pipe[KEY_LAT-2:0], key_rd_en};
    addr_pipe[0] <= key_addr;
    for (int i = 1; i < KEY_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    if (key_rd_en) begin
      addr_q.push_back(key_addr);
      n_rd++;
    end
  end
  assign key_data_vld = vld_pipe[KEY_LAT-1];
  assign key_data     = (addr_pipe[KEY_LAT-1] < 9'd72) ? rk[addr_pipe[KEY_LAT-1]] : 64'd0;

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [63:0] z4;
    logic [63:0] tmp;
    z4 = 64'hfdc94c3a046d678b;
    for (int i = 0; i < 4; i++) rk[i] = key[64*i +: 64];
    for (int i = 4; i < 72; i++) begin
      tmp = rol(rk[i-1], 61) ^ rk[i-3];
      tmp = tmp ^ rol(tmp, 63);
      rk[i] = ~rk[i-4] ^ tmp ^ {63'd0, z4[(i-4) % 62]} ^ 64'd3;
    end
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [63:0] a, b, t;
    a = pt[127:64];
    b = pt[63:0];
    for (int i = 0; i < 72; i++) begin
      t = a;
      a = b ^ ((rol(a, 1) & rol(a, 8)) ^ rol(a, 2)) ^ rk[i];
      b = t;
    end
    return {a, b};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys();
    key_compute_start = 1'b1;
    tick();
    key_compute_start = 1'b0;
    expand(KEY);
    repeat (5) tick();
    key_mem_full = 1'b1;
    tick();
    key_mem_full = 1'b0;
  endtask

  // Returns T, the cycle in which in_vld & in_rdy are both high.
  task automatic send(input logic [127:0] pt, output int t_acc);
    in_data = pt;
    in_vld  = 1'b1;
    for (int i = 0; i < 200 && !in_rdy; i++) tick();
    chk_b("accept_in_rdy", in_rdy, 1'b1);
    t_acc = cyc;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic recv(output logic [127:0] d, output int t_out);
    for (int i = 0; i < 200 && !out_vld; i++) tick();
    chk_b("out_vld_seen", out_vld, 1'b1);
    d     = out_data;
    t_out = cyc;
  endtask

  task automatic chk_addr_seq(input string tag, input int base, input bit down);
    int bad;
    bad = 0;
    if (addr_q.size() != base + 72) bad++;
    else
      for (int i = 0; i < 72; i++)
        if (addr_q[base+i] != 9'(down ? 71 - i : i)) bad++;
    chk_i(tag, bad, 0);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] pts [4];
    int t0, t1, tprev, base, rd0, bad;

    rst = 1'b1;
    key_compute_start = 1'b0;
    key_mem_full = 1'b0;
    in_vld = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
`ifdef SIMON_DECRYPT_EN
    in_decrypt = 1'b0;
`endif
    repeat (3) tick();
    chk_b("rst_in_rdy", in_rdy, 1'b0);
    chk_b("rst_key_rd_en", key_rd_en, 1'b0);
    chk_i("rst_key_addr", int'(key_addr), 0);
    chk_b("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_data", out_data, 128'd0);
    chk_b("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Plaintext offered before the key memory is full must be held off.
    rd0 = n_rd;
    in_data = PT;
    in_vld = 1'b1;
    bad = 0;
    repeat (10) begin
      if (in_rdy !== 1'b0) bad++;
      tick();
    end
    in_vld = 1'b0;
    chk_i("nokey_in_rdy_high", bad, 0);
    chk_i("nokey_reads", n_rd - rd0, 0);

    load_keys();
    chk("model_vector", ref_enc(PT), CT);

    // Known-answer block, then a 20-cycle output stall.
    base = addr_q.size();
    send(PT, t0);
    recv(d, t1);
    chk_i("kat_latency", t1 - t0, 75);
    chk("kat_data", d, CT);
    chk_addr_seq("enc_addr_seq", base, 1'b0);
    repeat (20) begin
      chk_b("stall_out_vld", out_vld, 1'b1);
      chk("stall_out_data", out_data, CT);
      chk_b("stall_in_rdy", in_rdy, 1'b0);
      tick();
    end
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk_b("post_hs_in_rdy", in_rdy, 1'b1);
    chk_b("post_hs_busy", busy, 1'b0);
    chk_b("post_hs_out_vld", out_vld, 1'b0);

    // Restart of the key schedule at T+30 aborts the block.
    send(128'd0, t0);
    while (cyc < t0 + 30) tick();
    key_compute_start = 1'b1;
    tick();
    key_compute_start = 1'b0;
    chk_b("abort_key_rd_en", key_rd_en, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    bad = 0;
    repeat (12) begin
      if (out_vld !== 1'b0 || in_rdy !== 1'b0) bad++;
      tick();
    end
    chk_i("abort_quiet", bad, 0);
    key_mem_full = 1'b1;
    tick();
    key_mem_full = 1'b0;
    send(PT, t0);
    recv(d, t1);
    chk("after_abort_data", d, CT);
    chk_i("after_abort_latency", t1 - t0, 75);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;

`ifdef SIMON_DECRYPT_EN
    base = addr_q.size();
    in_decrypt = 1'b1;
    send(CT, t0);
    in_decrypt = 1'b0;
    recv(d, t1);
    chk("dec_data", d, PT);
    chk_i("dec_latency", t1 - t0, 75);
    chk_addr_seq("dec_addr_seq", base, 1'b1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
`endif

    // Four back-to-back blocks with the output always ready.
    pts[0] = 128'd0;
    pts[1] = {128{1'b1}};
    pts[2] = 128'h0123456789abcdef_fedcba9876543210;
    pts[3] = PT;
    out_rdy = 1'b1;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      send(pts[k], t0);
      if (k > 0) chk_i("b2b_spacing", t0 - tprev, 76);
      tprev = t0;
      recv(d, t1);
      chk("b2b_data", d, ref_enc(pts[k]));
      tick();
    end
    out_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
